// File: rtl/ds18b20_sequencer.sv
// ds18b20_sequencer: steps the one_wire bit engine through one DS18B20
// temperature read (reset, Skip ROM + Convert T, poll, reset, Skip ROM +
// Read Scratchpad). Build option DS_CRC_EN adds the 9th scratchpad byte
// and a bit-serial Dallas CRC8 check over bytes 0..7.
module ds18b20_sequencer #(
    parameter int POLL_MAX = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error,
    output logic [15:0] temp,
    output logic [71:0] scratch,
    output logic        ow_reset,
    output logic        ow_write,
    output logic        ow_read,
    output logic [63:0] ow_in_data,
    output logic [5:0]  ow_start_bit,
    output logic [5:0]  ow_end_bit,
    input  logic        ow_busy,
    input  logic        ow_presence,
    input  logic [63:0] ow_out_data
);

    // Handshake phase of the current step, plus the terminal states
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_ACK, S_WAIT, S_EVAL, S_CHK, S_FIN
    } state_t;

    // Which bus transaction the handshake is currently running
    typedef enum logic [2:0] {
        ST_RST1, ST_CMD1, ST_POLL, ST_RST2, ST_CMD2, ST_RD8, ST_RD1
    } step_t;

    localparam logic [9:0] POLL_LIM = 10'(POLL_MAX);
    localparam logic [1:0] E_OK     = 2'b00;
    localparam logic [1:0] E_NOPRES = 2'b01;
    localparam logic [1:0] E_TMO    = 2'b10;
`ifdef DS_CRC_EN
    localparam logic [1:0] E_CRC    = 2'b11;
`endif

    state_t      state, state_d;
    step_t       step, step_d;
    logic [1:0]  err_d;
    logic [9:0]  poll_cnt;
    logic        seq_start;

`ifdef DS_CRC_EN
    logic [71:0] rx_buf;
    logic [7:0]  crc, crc_nxt;
    logic [5:0]  chk_cnt;
    logic        crc_fb;

    // One CRC8 step (reflected poly 0x8C) over the next scratchpad bit
    always_comb begin
        crc_fb  = crc[0] ^ rx_buf[{1'b0, chk_cnt}];
        crc_nxt = {1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
    end
`endif

    assign seq_start = (state == S_IDLE) && (state_d == S_ISSUE);

    // Next-state: run ISSUE/ACK/WAIT/EVAL per step, EVAL picks the next step
    always_comb begin
        state_d = state;
        step_d  = step;
        err_d   = error;
        case (state)
            S_IDLE: begin
                if (start && !ow_busy) begin
                    state_d = S_ISSUE;
                    step_d  = ST_RST1;
                end
            end
            S_ISSUE: state_d = S_ACK;
            S_ACK:   if (ow_busy)  state_d = S_WAIT;
            S_WAIT:  if (!ow_busy) state_d = S_EVAL;
            S_EVAL: begin
                state_d = S_ISSUE;
                case (step)
                    ST_RST1, ST_RST2: begin
                        if (!ow_presence) begin
                            state_d = S_FIN;
                            err_d   = E_NOPRES;
                        end else begin
                            step_d = (step == ST_RST1) ? ST_CMD1 : ST_CMD2;
                        end
                    end
                    ST_CMD1: step_d = ST_POLL;
                    ST_POLL: begin
                        // DS18B20 reads back all zeros until conversion ends
                        if (ow_out_data[7:0] != 8'h00) begin
                            step_d = ST_RST2;
                        end else if (poll_cnt + 10'd1 >= POLL_LIM) begin
                            state_d = S_FIN;
                            err_d   = E_TMO;
                        end
                    end
                    ST_CMD2: step_d = ST_RD8;
`ifdef DS_CRC_EN
                    ST_RD8:  step_d = ST_RD1;
                    ST_RD1:  state_d = S_CHK;
`else
                    ST_RD8: begin
                        state_d = S_FIN;
                        err_d   = E_OK;
                    end
`endif
                    default: state_d = S_IDLE;
                endcase
            end
`ifdef DS_CRC_EN
            S_CHK: begin
                if (chk_cnt == 6'd63) begin
                    state_d = S_FIN;
                    err_d   = (crc_nxt == rx_buf[71:64]) ? E_OK : E_CRC;
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status and engine command pulses decode straight from the state
    always_comb begin
        busy     = (state != S_IDLE) && (state != S_FIN);
        done     = (state == S_FIN);
        ow_reset = (state == S_ISSUE) && (step == ST_RST1 || step == ST_RST2);
        ow_write = (state == S_ISSUE) && (step == ST_CMD1 || step == ST_CMD2);
        ow_read  = (state == S_ISSUE) &&
                   (step == ST_POLL || step == ST_RD8 || step == ST_RD1);
    end

    // State and step registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            step  <= ST_RST1;
        end else begin
            state <= state_d;
            step  <= step_d;
        end
    end

    // Engine data/bit indices: loaded on entry to ISSUE, held through WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            ow_in_data   <= '0;
            ow_start_bit <= '0;
            ow_end_bit   <= '0;
        end else if (state_d == S_ISSUE) begin
            ow_in_data   <= '0;
            ow_start_bit <= 6'd0;
            ow_end_bit   <= 6'd0;
            case (step_d)
                ST_CMD1: begin ow_in_data <= 64'h44CC; ow_end_bit <= 6'd15; end
                ST_CMD2: begin ow_in_data <= 64'hBECC; ow_end_bit <= 6'd15; end
                ST_POLL: ow_end_bit <= 6'd7;
                ST_RD8:  ow_end_bit <= 6'd63;
                ST_RD1:  ow_end_bit <= 6'd7;
                default: ;
            endcase
        end
    end

    // Conversion poll counter, saturating at the limit
    always_ff @(posedge clk) begin
        if (reset || seq_start) begin
            poll_cnt <= '0;
        end else if (state == S_EVAL && step == ST_POLL &&
                     ow_out_data[7:0] == 8'h00 && poll_cnt != POLL_LIM) begin
            poll_cnt <= poll_cnt + 10'd1;
        end
    end

`ifdef DS_CRC_EN
    // Scratchpad capture and bit-serial CRC over bytes 0..7
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_buf  <= '0;
            crc     <= '0;
            chk_cnt <= '0;
        end else begin
            if (state == S_EVAL && step == ST_RD8) rx_buf[63:0]  <= ow_out_data;
            if (state == S_EVAL && step == ST_RD1) rx_buf[71:64] <= ow_out_data[7:0];
            if (state != S_CHK && state_d == S_CHK) begin
                crc     <= '0;
                chk_cnt <= '0;
            end else if (state == S_CHK) begin
                crc     <= crc_nxt;
                chk_cnt <= chk_cnt + 6'd1;
            end
        end
    end
`endif

    // Results: error always latched at FIN, temp/scratch only on success
    always_ff @(posedge clk) begin
        if (reset) begin
            error   <= E_OK;
            temp    <= '0;
            scratch <= '0;
        end else if (state_d == S_FIN) begin
            error <= err_d;
            if (err_d == E_OK) begin
`ifdef DS_CRC_EN
                scratch <= rx_buf;
                temp    <= rx_buf[15:0];
`else
                scratch <= {8'h00, ow_out_data};
                temp    <= ow_out_data[15:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_ds18b20_sequencer.sv
// tb_ds18b20_sequencer: behavioural one_wire engine + DS18B20 responder,
// directed and randomized read sequences checked against a transaction model.
module tb_ds18b20_sequencer;

    localparam int POLL_MAX = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [1:0]  error;
    logic [15:0] temp;
    logic [71:0] scratch;
    logic        ow_reset, ow_write, ow_read;
    logic [63:0] ow_in_data;
    logic [5:0]  ow_start_bit, ow_end_bit;
    logic        ow_busy = 1'b0;
    logic        ow_presence = 1'b0;
    logic [63:0] ow_out_data = '0;

    ds18b20_sequencer #(.POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .error(error), .temp(temp), .scratch(scratch),
        .ow_reset(ow_reset), .ow_write(ow_write), .ow_read(ow_read),
        .ow_in_data(ow_in_data), .ow_start_bit(ow_start_bit), .ow_end_bit(ow_end_bit),
        .ow_busy(ow_busy), .ow_presence(ow_presence), .ow_out_data(ow_out_data)
    );

    always #20 clk = ~clk;

    // scenario configuration (written only by the stimulus process)
    bit          cfg_pres = 1'b1;
    int          cfg_npoll = 0;
    int          cfg_lat = 0;
    logic [71:0] sp72 = '0;

    // engine/device model state and monitors (written only by the model)
    int          eng_cnt = 0;
    int          mode = 0;
    int          poll_n = 0;
    int          polls_total = 0;
    int          rd8_total = 0;
    int          wide = 0;
    int          overlap = 0;
    int          bad_bits = 0;
    bit          prev_pulse = 1'b0;
    logic [15:0] wr_q[$];

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_temp = '0;
    logic [71:0] exp_scr = '0;

    task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [63:0] d);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return c;
    endfunction

    // One_wire engine + DS18B20: busy for a few cycles per command, answers
    // polls with 00 until the configured count, then the scratchpad.
    always @(posedge clk) begin : engine
        logic pulse;
        pulse = ow_reset | ow_write | ow_read;
        if (pulse && prev_pulse) wide <= wide + 1;
        prev_pulse <= pulse;
        if (pulse && (ow_busy || eng_cnt != 0)) overlap <= overlap + 1;
        if (ow_reset) ow_presence <= cfg_pres;
        if (ow_write) begin
            wr_q.push_back(ow_in_data[15:0]);
            if (ow_start_bit != 6'd0 || ow_end_bit != 6'd15) bad_bits <= bad_bits + 1;
            if (ow_in_data[15:0] == 16'h44CC) begin
                mode   <= 0;
                poll_n <= 0;
            end else begin
                mode <= 1;
            end
        end
        if (ow_read) begin
            if (mode == 0) begin
                ow_out_data <= {56'h0, (poll_n < cfg_npoll) ? 8'h00 : 8'hFF};
                poll_n      <= poll_n + 1;
                polls_total <= polls_total + 1;
                if (ow_end_bit != 6'd7) bad_bits <= bad_bits + 1;
            end else if (mode == 1) begin
                ow_out_data <= sp72[63:0];
                mode        <= 2;
                rd8_total   <= rd8_total + 1;
                if (ow_end_bit != 6'd63) bad_bits <= bad_bits + 1;
            end else begin
                ow_out_data <= {56'h0, sp72[71:64]};
                if (ow_end_bit != 6'd7) bad_bits <= bad_bits + 1;
            end
        end
        if (pulse && eng_cnt == 0) begin
            ow_busy <= 1'b1;
            eng_cnt <= (cfg_lat > 0) ? cfg_lat : int'($urandom_range(1, 5));
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) ow_busy <= 1'b0;
        end
    end

    // Run one full read and compare against the transaction-level expectation
    task automatic run_seq(input string tag);
        int          base_wr, base_poll, cyc, idle, e_polls, e_nwr;
        logic [1:0]  e_err;
        logic [15:0] w0, w1;
        if (!cfg_pres) begin
            e_err = 2'd1; e_polls = 0; e_nwr = 0;
        end else if (cfg_npoll >= POLL_MAX) begin
            e_err = 2'd2; e_polls = POLL_MAX; e_nwr = 1;
        end else begin
            e_polls = cfg_npoll + 1; e_nwr = 2;
`ifdef DS_CRC_EN
            e_err = (crc8(sp72[63:0]) == sp72[71:64]) ? 2'd0 : 2'd3;
`else
            e_err = 2'd0;
`endif
        end
        if (e_err == 2'd0) begin
`ifdef DS_CRC_EN
            exp_scr = sp72;
`else
            exp_scr = {8'h00, sp72[63:0]};
`endif
            exp_temp = exp_scr[15:0];
        end
        base_wr = wr_q.size();
        base_poll = polls_total;
        cyc = 0;
        while (ow_busy && cyc < 200) begin @(negedge clk); cyc++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_on"}, busy, 1);
        cyc = 0; idle = 0;
        while (!done && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (ow_busy) idle = 0; else idle++;
            if (!done) start = ($urandom_range(0, 15) == 0);
        end
        start = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_error"}, error, e_err);
        chk({tag, "_temp"}, temp, exp_temp);
        chk({tag, "_scratch"}, scratch, exp_scr);
        chk({tag, "_polls"}, polls_total - base_poll, e_polls);
        chk({tag, "_nwrites"}, wr_q.size() - base_wr, e_nwr);
        w0 = (wr_q.size() > base_wr) ? wr_q[base_wr] : 16'h0;
        w1 = (wr_q.size() > base_wr + 1) ? wr_q[base_wr + 1] : 16'h0;
        if (e_nwr >= 1) chk({tag, "_write0"}, w0, 16'h44CC);
        if (e_nwr >= 2) chk({tag, "_write1"}, w1, 16'hBECC);
`ifdef DS_CRC_EN
        if (!cfg_pres) chk({tag, "_done_lat"}, idle <= 3, 1);
`else
        if (e_err != 2'd2) chk({tag, "_done_lat"}, idle <= 3, 1);
`endif
        @(negedge clk);
        chk({tag, "_done_1cyc"}, done, 0);
        chk({tag, "_no_requeue"}, busy, 0);
        chk({tag, "_pulse_width"}, wide, 0);
        chk({tag, "_cmd_overlap"}, overlap, 0);
        chk({tag, "_bit_idx"}, bad_bits, 0);
    endtask

    initial begin
        int cyc, base_rd8;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_temp", temp, 0);
        chk("rst_scratch", scratch, 0);
        chk("rst_pulses", {ow_reset, ow_write, ow_read}, 0);
        chk("rst_cmd", {ow_in_data, ow_start_bit, ow_end_bit}, 0);
        reset = 1'b0;
        @(negedge clk);

        // nominal read: 85.0 degC power-on scratchpad, 3 busy polls
        sp72 = {8'h1C, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h05, 8'h50};
        cfg_pres = 1'b1; cfg_npoll = 3; cfg_lat = 0;
        run_seq("nominal");

        // no device on the bus
        sp72 = {8'h1C, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h12, 8'h34};
        cfg_pres = 1'b0;
        run_seq("nodev");

        // CRC corruption in byte 8
        sp72 = {8'h1D, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h01, 8'h90};
        cfg_pres = 1'b1; cfg_npoll = 0;
        run_seq("crcbad");

        // conversion never finishes
        cfg_npoll = 5000; cfg_lat = 1;
        run_seq("timeout");
        cfg_lat = 0;

        // reset in the middle of the 64-bit read, engine still running
        sp72 = {8'h1C, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h05, 8'h50};
        cfg_npoll = 1; cfg_lat = 20;
        base_rd8 = rd8_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rd8_total == base_rd8 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("mid_rd8_reached", rd8_total != base_rd8, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_temp = '0; exp_scr = '0;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_error", error, 0);
        chk("mid_temp", temp, 0);
        chk("mid_scratch", scratch, 0);
        chk("mid_pulses", {ow_reset, ow_write, ow_read}, 0);
        chk("mid_cmd", {ow_in_data, ow_start_bit, ow_end_bit}, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_start_eng_busy", busy, 0);
        @(negedge clk);
        chk("mid_no_reset_cmd", {ow_reset, busy}, 0);
        cfg_lat = 0;
        run_seq("after_rst");

        // randomized devices
        for (int n = 0; n < 8; n++) begin
            sp72[63:0] = {$urandom, $urandom};
            sp72[71:64] = ($urandom_range(0, 1) == 1) ? crc8(sp72[63:0]) : 8'($urandom);
            cfg_pres = ($urandom_range(0, 5) != 0);
            cfg_npoll = $urandom_range(0, 6);
            run_seq($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
